// File: rtl/img_sched_pkg.sv
// img_sched_pkg: shared sizes, control states and read-response tags for the image memory scheduler.
package img_sched_pkg;
  localparam int IMG_WORDS = 784;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, CLEAR, LOCKED} state_t;
  localparam logic RID_VGA = 1'b0;
  localparam logic RID_NN = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; prio_b forces requester b to win without moving the pointer.
module rr_arb2 (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic prio_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic ptr;
  assign gnt_b = req_b & (prio_b | ~req_a | ptr);
  assign gnt_a = req_a & ~gnt_b;
  always_ff @(posedge CLOCK_50)
    if (reset) ptr <= 1'b0;
    else if (req_a & req_b & ~prio_b) ptr <= ~ptr;
endmodule

// File: rtl/image_mem_scheduler.sv
// image_mem_scheduler: arbitrates draw writes, VGA/NN reads, hardware clear and inference lock on the image memory.
// Optional clear sequencer compiled in with IMG_SCHED_CLEAR_EN.
module image_mem_scheduler #(
  parameter int IMG_WORDS = img_sched_pkg::IMG_WORDS,
  parameter int ADDR_W = img_sched_pkg::ADDR_W,
  parameter int DATA_W = img_sched_pkg::DATA_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              dw_req,
  input  logic [ADDR_W-1:0] dw_addr,
  input  logic [DATA_W-1:0] dw_data,
  output logic              dw_gnt,
  input  logic              vr_req,
  input  logic [ADDR_W-1:0] vr_addr,
  output logic              vr_gnt,
  output logic              vr_rvalid,
  input  logic              nn_req,
  input  logic [ADDR_W-1:0] nn_addr,
  output logic              nn_gnt,
  output logic              nn_rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic              nn_lock,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);
  import img_sched_pkg::*;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(IMG_WORDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_WORDS - 1);
  state_t state;
  logic rv_q, rid_q, oor_q, rd, clr_wr;
  logic [ADDR_W-1:0] raddr_q;
  rr_arb2 u_arb (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .req_a(vr_req & ~reset),
    .req_b(nn_req & ~reset),
    .prio_b(state == LOCKED),
    .gnt_a(vr_gnt),
    .gnt_b(nn_gnt)
  );
  assign rd = vr_gnt | nn_gnt;
  assign mem_raddr = nn_gnt ? nn_addr : vr_gnt ? vr_addr : raddr_q;
  assign dw_gnt = dw_req & ~reset & (state == IDLE);
  assign mem_we = clr_wr | (dw_gnt & (dw_addr < LIMIT));
  assign mem_wdata = dw_gnt ? dw_data : '0;
  assign vr_rvalid = rv_q & (rid_q == RID_VGA);
  assign nn_rvalid = rv_q & (rid_q == RID_NN);
  assign rdata = (rv_q & ~oor_q) ? mem_rdata : '0;
`ifdef IMG_SCHED_CLEAR_EN
  logic pend, done_q;
  logic [ADDR_W-1:0] cnt;
  assign clr_wr = (state == CLEAR) & ~reset;
  assign mem_waddr = clr_wr ? cnt : dw_gnt ? dw_addr : '0;
  assign clr_busy = state == CLEAR;
  assign clr_done = done_q;
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      state <= IDLE;
      pend <= 1'b0;
      cnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE:
          if (nn_lock) begin
            state <= LOCKED;
            pend <= pend | clr_start;
          end else if (pend | clr_start) begin
            state <= CLEAR;
            pend <= 1'b0;
            cnt <= '0;
          end
        LOCKED: begin
          pend <= pend | clr_start;
          if (!nn_lock) state <= IDLE;
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
`else
  logic clr_unused;
  assign clr_unused = clr_start;
  assign clr_wr = 1'b0;
  assign mem_waddr = dw_gnt ? dw_addr : '0;
  assign clr_busy = 1'b0;
  assign clr_done = 1'b0;
  always_ff @(posedge CLOCK_50)
    if (reset) state <= IDLE;
    else state <= nn_lock ? LOCKED : IDLE;
`endif
  // Response tag: a read granted this cycle returns on the next one.
  always_ff @(posedge CLOCK_50)
    if (reset) begin
      rv_q <= 1'b0;
      rid_q <= RID_VGA;
      oor_q <= 1'b0;
      raddr_q <= '0;
    end else begin
      rv_q <= rd;
      rid_q <= nn_gnt ? RID_NN : RID_VGA;
      oor_q <= mem_raddr >= LIMIT;
      if (rd) raddr_q <= mem_raddr;
    end
endmodule

// File: tb/tb_image_mem_scheduler.sv
// tb_image_mem_scheduler: directed plus randomized checks of the scheduler against a spec-level model.
// Clear tests run when IMG_SCHED_CLEAR_EN is defined.
module tb_image_mem_scheduler;
  localparam int N = 784;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_LOCKED = 2;
`ifdef IMG_SCHED_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  logic CLOCK_50 = 1'b0, reset = 1'b1;
  logic dw_req = 0, vr_req = 0, nn_req = 0, nn_lock = 0, clr_start = 0;
  logic [9:0] dw_addr = 0, vr_addr = 0, nn_addr = 0;
  logic [31:0] dw_data = 0;
  logic dw_gnt, vr_gnt, vr_rvalid, nn_gnt, nn_rvalid, clr_busy, clr_done, mem_we;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic [9:0] mem_waddr, mem_raddr;
  bit [31:0] mem_arr [1024];
  bit wr [1024];
  logic [31:0] img [N];
  int checks = 0, failures = 0;
  int mode, ccount, rv_who;
  bit pend, ptr_nn, done_exp;
  logic [9:0] last_raddr;
  logic [31:0] rv_data;
  logic o_dw, o_vr, o_nn, o_we, o_busy, o_done;
  logic [9:0] o_waddr;
  logic [31:0] o_wdata;

  image_mem_scheduler dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .dw_req(dw_req), .dw_addr(dw_addr), .dw_data(dw_data), .dw_gnt(dw_gnt),
    .vr_req(vr_req), .vr_addr(vr_addr), .vr_gnt(vr_gnt), .vr_rvalid(vr_rvalid),
    .nn_req(nn_req), .nn_addr(nn_addr), .nn_gnt(nn_gnt), .nn_rvalid(nn_rvalid),
    .rdata(rdata), .nn_lock(nn_lock), .clr_start(clr_start), .clr_busy(clr_busy),
    .clr_done(clr_done), .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [31:0] init_val(input int a);
    return 32'(a) * 32'h9E3779B1 + 32'h1234;
  endfunction

  // Memory with registered read, read-before-write on the same edge.
  always @(posedge CLOCK_50) begin
    if (mem_we) begin
      mem_arr[mem_waddr] <= mem_wdata;
      wr[mem_waddr] <= 1'b1;
    end
    mem_rdata <= wr[mem_raddr] ? mem_arr[mem_raddr] : init_val(int'(mem_raddr));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [9:0] rnd_addr();
    return ($urandom_range(0, 9) == 0) ? 10'($urandom_range(784, 1023)) : 10'($urandom_range(0, 783));
  endfunction

  task automatic tick();
    bit e_dw, e_we, g_vr, g_nn, both;
    logic [9:0] e_waddr, e_raddr;
    logic [31:0] e_wdata;
    both = vr_req && nn_req;
    e_dw = dw_req && mode == M_IDLE;
    e_we = mode == M_CLEAR || (e_dw && dw_addr < N);
    e_waddr = mode == M_CLEAR ? 10'(ccount) : dw_addr;
    e_wdata = mode == M_CLEAR ? 32'd0 : dw_data;
    if (mode == M_LOCKED) begin g_nn = nn_req; g_vr = vr_req && !nn_req; end
    else if (both) begin g_nn = ptr_nn; g_vr = !ptr_nn; end
    else begin g_nn = nn_req; g_vr = vr_req; end
    e_raddr = g_nn ? nn_addr : g_vr ? vr_addr : last_raddr;
    @(negedge CLOCK_50);
    o_dw = dw_gnt; o_vr = vr_gnt; o_nn = nn_gnt; o_we = mem_we;
    o_busy = clr_busy; o_done = clr_done; o_waddr = mem_waddr; o_wdata = mem_wdata;
    if (!reset) begin
      chk("dw_gnt", dw_gnt, e_dw);
      chk("vr_gnt", vr_gnt, g_vr);
      chk("nn_gnt", nn_gnt, g_nn);
      chk("mem_we", mem_we, e_we);
      if (e_we) begin
        chk("mem_waddr", mem_waddr, e_waddr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("mem_raddr", mem_raddr, e_raddr);
      chk("vr_rvalid", vr_rvalid, rv_who == 1);
      chk("nn_rvalid", nn_rvalid, rv_who == 2);
      if (rv_who != 0) chk("rdata", rdata, rv_data);
      chk("clr_busy", clr_busy, mode == M_CLEAR);
      chk("clr_done", clr_done, done_exp);
    end
    @(posedge CLOCK_50);
    if (reset) begin
      mode = M_IDLE; pend = 0; ptr_nn = 0; done_exp = 0; ccount = 0; last_raddr = 0; rv_who = 0;
    end else begin
      rv_who = g_nn ? 2 : g_vr ? 1 : 0;
      rv_data = (e_raddr < N) ? img[e_raddr] : 32'd0;
      if (rv_who != 0) last_raddr = e_raddr;
      if (e_we) img[e_waddr] = e_wdata;
      if (both && mode != M_LOCKED) ptr_nn = !ptr_nn;
      done_exp = 0;
      case (mode)
        M_IDLE:
          if (nn_lock) begin mode = M_LOCKED; pend = CLR_EN && (pend || clr_start); end
          else if (CLR_EN && (pend || clr_start)) begin mode = M_CLEAR; pend = 0; ccount = 0; end
        M_LOCKED: begin
          pend = CLR_EN && (pend || clr_start);
          if (!nn_lock) mode = M_IDLE;
        end
        default:
          if (ccount == N - 1) begin mode = M_IDLE; done_exp = 1; end
          else ccount++;
      endcase
    end
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnts"}, {dw_gnt, vr_gnt, nn_gnt}, 3'b000);
    chk({tag, "_rvalid"}, {vr_rvalid, nn_rvalid}, 2'b00);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_waddr"}, mem_waddr, 10'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_raddr"}, mem_raddr, 10'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_clr"}, {clr_busy, clr_done}, 2'b00);
  endtask

  task automatic rand_cycles(input int n, input int lock_pct);
    for (int i = 0; i < n; i++) begin
      dw_req = 1'($urandom_range(0, 1)); dw_addr = rnd_addr(); dw_data = $urandom;
      vr_req = 1'($urandom_range(0, 1)); vr_addr = rnd_addr();
      nn_req = 1'($urandom_range(0, 1)); nn_addr = rnd_addr();
      if ($urandom_range(0, 99) < lock_pct) nn_lock = !nn_lock;
      tick();
    end
    dw_req = 0; vr_req = 0; nn_req = 0; nn_lock = 0;
    tick();
    tick();
  endtask

  initial begin
    int busy_n, done_n;
    bit reached;
    for (int i = 0; i < N; i++) img[i] = init_val(i);
    @(posedge CLOCK_50);
    #1;
    tick();
    check_zero("reset");
    reset = 0;
    // single draw write
    dw_req = 1; dw_addr = 10'd29; dw_data = 32'd1;
    tick();
    chk("dw29_gnt", o_dw, 1'b1);
    chk("dw29_we", o_we, 1'b1);
    chk("dw29_waddr", o_waddr, 10'd29);
    chk("dw29_wdata", o_wdata, 32'd1);
    dw_req = 0;
    // contended reads alternate starting with VGA
    vr_req = 1; nn_req = 1; vr_addr = 10'd29; nn_addr = 10'd5;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_vga", o_vr, (i % 2) == 0);
      chk("rr_nn", o_nn, (i % 2) == 1);
    end
    // lock: no writes, NN always wins
    nn_lock = 1;
    tick();
    dw_req = 1; dw_addr = 10'd100; dw_data = 32'hCAFE;
    for (int i = 0; i < 6; i++) begin
      nn_addr = rnd_addr(); vr_addr = rnd_addr();
      tick();
      chk("lock_dw", o_dw, 1'b0);
      chk("lock_we", o_we, 1'b0);
      chk("lock_nn", o_nn, 1'b1);
      chk("lock_vr", o_vr, 1'b0);
    end
    vr_req = 0; nn_req = 0; nn_lock = 0;
    tick();
    chk("unlock_dw_held", o_dw, 1'b0);
    tick();
    chk("unlock_dw", o_dw, 1'b1);
    dw_req = 0;
    rand_cycles(400, 5);
`ifdef IMG_SCHED_CLEAR_EN
    // clear from IDLE
    clr_start = 1;
    tick();
    clr_start = 0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 900; i++) begin
      dw_req = 1; dw_addr = rnd_addr(); dw_data = $urandom;
      vr_req = 1'($urandom_range(0, 1)); vr_addr = rnd_addr();
      nn_req = 1'($urandom_range(0, 1)); nn_addr = rnd_addr();
      clr_start = (i == 300);
      tick();
      busy_n += int'(o_busy); done_n += int'(o_done);
      if (o_done) break;
    end
    chk("clr_busy_cycles", busy_n, 784);
    chk("clr_done_pulses", done_n, 1);
    dw_req = 0; vr_req = 0; nn_req = 0; clr_start = 0;
    tick();
    chk("clr_no_restart", o_busy, 1'b0);
    // clear requested together with lock rise, then released
    nn_lock = 1; clr_start = 1;
    tick();
    clr_start = 0;
    tick();
    tick();
    chk("pend_locked_busy", o_busy, 1'b0);
    nn_lock = 0;
    tick();
    tick();
    chk("pend_idle_busy", o_busy, 1'b0);
    tick();
    chk("pend_clear_busy", o_busy, 1'b1);
    done_n = 0;
    for (int i = 0; i < 900; i++) begin
      vr_req = 1'($urandom_range(0, 1)); vr_addr = rnd_addr();
      tick();
      done_n += int'(o_done);
      if (o_done) break;
    end
    chk("pend_done", done_n, 1);
    vr_req = 0;
    rand_cycles(200, 0);
    // reset at clear address 400
    clr_start = 1;
    tick();
    clr_start = 0;
    reached = 0;
    for (int i = 0; i < 1000; i++) begin
      if (mode == M_CLEAR && ccount == 400) begin reached = 1; break; end
      tick();
    end
    chk("clr_reach_400", reached, 1'b1);
    reset = 1;
    tick();
    check_zero("clr_abort");
    reset = 0;
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      vr_req = 1; vr_addr = 10'(398 + i);
      tick();
      done_n += int'(o_done) + int'(o_busy);
    end
    vr_req = 0;
    tick();
    chk("abort_no_done", done_n, 0);
`else
    clr_start = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("noclr_we", o_we, 1'b0);
      chk("noclr_busy", o_busy, 1'b0);
      chk("noclr_done", o_done, 1'b0);
    end
    clr_start = 0;
`endif
    rand_cycles(200, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/image_mem_scheduler.md
# image_mem_scheduler

Arbitrates and sequences all access to the 28x28 image memory (784 words, 32-bit signed). Its clients are the keyboard drawing writer, the VGA refresh reader and the inference-engine reader. It also runs a hardware clear sequence and an inference lock that freezes the image during classification. It sits between those three clients and the image memory's single write port and single registered read port.

## Interface
Parameters:
- IMG_WORDS, 784, number of valid image words
- ADDR_W, 10, address width
- DATA_W, 32, data width

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- dw_req  in  1  draw write request
- dw_addr  in  ADDR_W  draw write address
- dw_data  in  DATA_W  draw write data
- dw_gnt  out  1  draw write accepted this cycle
- vr_req  in  1  VGA read request
- vr_addr  in  ADDR_W  VGA read address
- vr_gnt  out  1  VGA read accepted
- vr_rvalid  out  1  VGA read data valid
- nn_req  in  1  inference read request
- nn_addr  in  ADDR_W  inference read address
- nn_gnt  out  1  inference read accepted
- nn_rvalid  out  1  inference read data valid
- rdata  out  DATA_W  read data, shared by both readers
- nn_lock  in  1  level; freezes the image contents
- clr_start  in  1  pulse; request a memory clear
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse when a clear completes
- mem_we  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- mem_raddr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data, 1-cycle registered latency

## Operation
- Control FSM states: IDLE, CLEAR, LOCKED.
  - IDLE -> CLEAR on a pending clear when nn_lock=0.
  - IDLE -> LOCKED on nn_lock=1.
  - LOCKED -> IDLE on nn_lock=0. If a clear is pending, the FSM enters CLEAR on the next cycle.
  - CLEAR -> IDLE after writing address IMG_WORDS-1.
- Write path:
  - dw_gnt = dw_req in IDLE only. dw_gnt is 0 in CLEAR and LOCKED; the requester holds its request.
  - On a granted write with dw_addr < IMG_WORDS: mem_we=1, mem_waddr=dw_addr, mem_wdata=dw_data.
  - On a granted write with dw_addr >= IMG_WORDS: the grant is still given and the write is dropped (mem_we=0).
- Clear:
  - The clear counter runs 0..IMG_WORDS-1 and writes 0 at each address, one write per cycle. A full clear is 784 cycles.
  - clr_busy=1 throughout CLEAR.
  - clr_start received during CLEAR is ignored.
  - clr_start received in LOCKED sets a pending flag. The flag clears when CLEAR is entered.
- Read path (all states):
  - Only one read is granted per cycle.
  - If both vr_req and nn_req are asserted, a 2-way round-robin selects the grant. The pointer moves to the other requester after each contended grant.
  - In LOCKED, nn_req has fixed priority over vr_req.
  - A lone request is granted immediately.
  - mem_raddr is the granted address. If no read is granted, mem_raddr holds its last value.
  - A read with address >= IMG_WORDS is granted and returns rdata=0.
- Response:
  - The matching rvalid asserts exactly one cycle after the grant.
  - rdata = mem_rdata, or 0 for an out-of-range read. rdata is valid only while an rvalid is high.
- No read/write forwarding. A same-cycle read and write to the same address returns whatever the memory returns.

## Timing
- Grants are combinational from the requests and the registered state; a transfer occurs on the cycle where req & gnt.
- Read latency is 1 cycle from grant to rvalid. The block sustains one read per cycle.
- Reset values: all gnt/rvalid outputs 0, mem_we=0, mem_waddr=0, mem_raddr=0, mem_wdata=0, rdata=0, clr_busy=0, clr_done=0. FSM=IDLE, round-robin pointer favours VGA, pending flag=0, clear counter=0.
- Reset mid-clear aborts the clear with no clr_done pulse. The memory is left partially cleared.
- clr_done pulses on the cycle after the final clear write, which is the cycle the FSM returns to IDLE.
- Simultaneous nn_lock rise and clr_start while in IDLE: LOCKED wins and the clear becomes pending.

## Configuration
- IMG_SCHED_CLEAR_EN defined: the clear sequencer, pending flag and CLEAR state are compiled in.
- IMG_SCHED_CLEAR_EN undefined:
  - clr_start is ignored.
  - clr_busy and clr_done are tied to 0.
  - The FSM has only IDLE and LOCKED.

## Structure
- Shared package img_sched_pkg:
  - IMG_WORDS, ADDR_W, DATA_W
  - state enum (IDLE, CLEAR, LOCKED)
  - requester-id constants (RID_VGA, RID_NN), used to tag the 1-cycle read response
- Sub-module rr_arb2 holds the 2-requester round-robin arbiter with its pointer register and a priority-override input (used in LOCKED).

## Test plan
- Draw write with dw_req=1, addr=29, data=1 in IDLE -> same cycle dw_gnt=1, mem_we=1, mem_waddr=29, mem_wdata=1.
- vr_req and nn_req both held high for 4 cycles in IDLE -> grants alternate VGA, NN, VGA, NN. Each rvalid follows its grant 1 cycle later, carrying mem_rdata.
- nn_lock=1 with dw_req=1 -> dw_gnt=0 and mem_we=0 for the whole lock. Contended reads always go to NN. The write is granted on the first cycle after nn_lock falls.
- clr_start in IDLE -> clr_busy=1 for 784 cycles, writes of 0 at addresses 0..783, clr_done pulses once, and dw_gnt=0 throughout.
- clr_start during LOCKED, then nn_lock=0 -> CLEAR is entered on the following cycle and the full clear completes.
- reset asserted at clear address 400 -> all outputs 0 next cycle, no clr_done pulse. With the macro undefined, clr_start produces no mem_we.
